// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR transfer controller.
package lfsr_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LFSR_W_DEF = 7;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    DONE
  } state_e;

  // Shift left and insert the tap parity; valid for widths up to 16.
  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s,
    input logic [15:0] t,
    input int          w
  );
    logic [15:0] m;
    m = 16'((32'd1 << w) - 32'd1);
    return ((s << 1) | 16'(^(s & t))) & m;
  endfunction

endpackage

// File: rtl/lfsr_xfer_ctrl_core.sv
// LFSR keystream register with its tap mask.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int W = LFSR_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         seed_ld_i,
  input  logic [W-1:0] seed_i,
  input  logic         taps_ld_i,
  input  logic [W-1:0] taps_i,
  input  logic         step_i,
  output logic [W-1:0] state_o
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] taps_q;
  logic [15:0]  nxt;

  assign nxt     = lfsr_step(16'(lfsr_q), 16'(taps_q), W);
  assign state_o = lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= '0;
      taps_q <= '0;
    end else begin
      if (seed_ld_i)   lfsr_q <= seed_i;
      else if (step_i) lfsr_q <= nxt[W-1:0];
      if (taps_ld_i)   taps_q <= taps_i;
    end
  end

endmodule

// File: rtl/lfsr_xfer_ctrl.sv
// Walks a source buffer, XORs each byte with the LFSR keystream and
// writes it to a destination buffer; stalls the core while running.
module lfsr_xfer_ctrl
  import lfsr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LFSR_W = LFSR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed,
  input  logic              taps_ld,
  input  logic [LFSR_W-1:0] taps,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q, len_q, idx_q;
  logic [ADDR_W-1:0] idx_inc, addr_q;
  logic [DATA_W-1:0] rbuf_q, wdata_q;
  logic [LFSR_W-1:0] lfsr_st;
  logic              idle;

  assign idle    = (state_q == IDLE);
  assign idx_inc = idx_q + 1'b1;

  lfsr_core #(.W(LFSR_W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .seed_ld_i(idle & seed_ld),
    .seed_i   (seed),
    .taps_ld_i(idle & taps_ld),
    .taps_i   (taps),
    .step_i   (state_q == WR),
    .state_o  (lfsr_st)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (len == '0) ? DONE : RD;
      RD:   state_d = WAIT;
      WAIT: state_d = WR;
      WR:   state_d = (idx_inc == len_q) ? DONE : RD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = !idle;
    done      = (state_q == DONE);
    mem_rd_en = (state_q == RD);
    mem_wr_en = (state_q == WR);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (state_q == RD) mem_addr = src_q + idx_q;
    if (state_q == WR) begin
      mem_addr  = dst_q + idx_q;
      mem_wdata = rbuf_q ^ {{(DATA_W-LFSR_W){1'b0}}, lfsr_st};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rbuf_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      if (idle && start) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        len_q <= len;
        idx_q <= '0;
      end
      if (state_q == WAIT) rbuf_q <= mem_rdata;
      if (state_q == WR)   idx_q  <= idx_inc;
    end
  end

endmodule
